pixel_compositor: RTL and testbench

//  Final per-pixel stage of the GPU video path. Merges text-layer, object-layer and background pixels by fixed priority.

---
 rtl/gpu_pkg.sv | 17 +
 rtl/blink_timer.sv | 55 +++++
 rtl/pixel_compositor.sv | 105 ++++++++++
 tb/tb_pixel_compositor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU video output path.
package gpu_pkg;

  localparam int COLOR_W = 6;

  localparam int LAYER_TXT = 2;
  localparam int LAYER_OBJ = 1;
  localparam int LAYER_BG  = 0;

  typedef logic [COLOR_W-1:0] rgb_t;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_t;

endpackage

// File: rtl/blink_timer.sv
// Frame-based text blink: vsync edge detect, frame counter and SHOW/HIDE FSM.
module blink_timer
  import gpu_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic         gpu_clk,
  input  logic         rst,
  input  logic         vsync,        // active-high regardless of the external sync polarity
  input  logic         blink_en,
  output logic         blink_phase,
  output blink_state_t state_dbg
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  blink_state_t state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic         vsync_q;
  logic         frame_evt;

  assign frame_evt   = vsync & ~vsync_q;
  assign blink_phase = (state == SHOW);
  assign state_dbg   = state;

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      state   <= SHOW;
      cnt     <= '0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vsync_q <= vsync;
    end
  end

  // Disabling parks the timer at the start of a SHOW period so re-enabling begins with full visibility.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!blink_en) begin
      state_nxt = SHOW;
      cnt_nxt   = '0;
    end else if (frame_evt) begin
      if (cnt == LAST_FRAME) begin
        cnt_nxt   = '0;
        state_nxt = (state == SHOW) ? HIDE : SHOW;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// Final pixel stage: registers inputs (S1), merges text/object/background by priority (S2).
module pixel_compositor #(
  parameter int   COLOR_W      = gpu_pkg::COLOR_W,
  parameter int   BLINK_FRAMES = 30,
  parameter logic SYNC_ACTIVE  = 1'b0
) (
  input  logic               gpu_clk,
  input  logic               rst,
  input  logic               visible_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               text_valid,
  input  logic               text_color,
  input  logic               obj_valid,
  input  logic [COLOR_W-1:0] obj_rgb,
  input  logic [COLOR_W-1:0] bg_rgb,
  input  logic [COLOR_W-1:0] txt_rgb0,
  input  logic [COLOR_W-1:0] txt_rgb1,
  input  logic [2:0]         layer_en,
  input  logic               blink_en,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               visible_out,
  output logic               blink_phase
);

  import gpu_pkg::*;

  logic               s1_visible, s1_hsync, s1_vsync;
  logic               s1_text_valid, s1_text_color, s1_obj_valid;
  logic [COLOR_W-1:0] s1_obj_rgb, s1_bg_rgb, s1_txt_rgb0, s1_txt_rgb1;
  logic [2:0]         s1_layer_en;
  logic [COLOR_W-1:0] pix_sel;
  blink_state_t       blink_state;

  // S1: every input, palette included, is captured together with its pixel.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      s1_visible    <= 1'b0;
      s1_hsync      <= ~SYNC_ACTIVE;
      s1_vsync      <= ~SYNC_ACTIVE;
      s1_text_valid <= 1'b0;
      s1_text_color <= 1'b0;
      s1_obj_valid  <= 1'b0;
      s1_obj_rgb    <= '0;
      s1_bg_rgb     <= '0;
      s1_txt_rgb0   <= '0;
      s1_txt_rgb1   <= '0;
      s1_layer_en   <= '0;
    end else begin
      s1_visible    <= visible_in;
      s1_hsync      <= hsync_in;
      s1_vsync      <= vsync_in;
      s1_text_valid <= text_valid;
      s1_text_color <= text_color;
      s1_obj_valid  <= obj_valid;
      s1_obj_rgb    <= obj_rgb;
      s1_bg_rgb     <= bg_rgb;
      s1_txt_rgb0   <= txt_rgb0;
      s1_txt_rgb1   <= txt_rgb1;
      s1_layer_en   <= layer_en;
    end
  end

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .gpu_clk    (gpu_clk),
    .rst        (rst),
    .vsync      (s1_vsync == SYNC_ACTIVE),
    .blink_en   (blink_en),
    .blink_phase(blink_phase),
    .state_dbg  (blink_state)
  );

  always_comb begin
    pix_sel = '0;
    if (!s1_visible) begin
      pix_sel = '0;
    end else if (s1_layer_en[LAYER_TXT] && s1_text_valid && blink_phase) begin
      pix_sel = s1_text_color ? s1_txt_rgb1 : s1_txt_rgb0;
    end else if (s1_layer_en[LAYER_OBJ] && s1_obj_valid) begin
      pix_sel = s1_obj_rgb;
    end else if (s1_layer_en[LAYER_BG]) begin
      pix_sel = s1_bg_rgb;
    end
  end

  // S2: output registers feeding the DAC.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      rgb_out     <= '0;
      hsync_out   <= ~SYNC_ACTIVE;
      vsync_out   <= ~SYNC_ACTIVE;
      visible_out <= 1'b0;
    end else begin
      rgb_out     <= pix_sel;
      hsync_out   <= s1_hsync;
      vsync_out   <= s1_vsync;
      visible_out <= s1_visible;
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: priority, blanking, sync alignment, blink and async reset.
module tb_pixel_compositor;

  localparam int W = 6;

  logic         gpu_clk = 1'b0;
  logic         rst;
  logic         visible_in, hsync_in, vsync_in;
  logic         text_valid, text_color, obj_valid;
  logic [W-1:0] obj_rgb, bg_rgb, txt_rgb0, txt_rgb1;
  logic [2:0]   layer_en;
  logic         blink_en;
  logic [W-1:0] rgb_out;
  logic         hsync_out, vsync_out, visible_out, blink_phase;

  int checks = 0;
  int errors = 0;

  always #5 gpu_clk = ~gpu_clk;

  pixel_compositor #(
    .COLOR_W     (W),
    .BLINK_FRAMES(2),
    .SYNC_ACTIVE (1'b0)
  ) dut (
    .gpu_clk    (gpu_clk),
    .rst        (rst),
    .visible_in (visible_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .text_valid (text_valid),
    .text_color (text_color),
    .obj_valid  (obj_valid),
    .obj_rgb    (obj_rgb),
    .bg_rgb     (bg_rgb),
    .txt_rgb0   (txt_rgb0),
    .txt_rgb1   (txt_rgb1),
    .layer_en   (layer_en),
    .blink_en   (blink_en),
    .rgb_out    (rgb_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .visible_out(visible_out),
    .blink_phase(blink_phase)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    visible_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    text_valid = 1'b1; text_color = 1'b1; obj_valid = 1'b1;
    obj_rgb = '1; bg_rgb = '1; txt_rgb0 = '1; txt_rgb1 = '1;
    layer_en = 3'b111; blink_en = 1'b1;
    tick(); tick(); tick();
    checks++; if (rgb_out !== 6'h00) begin errors++; $display("FAIL reset_rgb got %h want 00", rgb_out); end
    checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
    checks++; if (vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync_out); end
    checks++; if (visible_out !== 1'b0) begin errors++; $display("FAIL reset_visible got %b want 0", visible_out); end
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL reset_blink got %b want 1", blink_phase); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    logic [W-1:0] exp_rgb [4] = '{6'h3F, 6'h0C, 6'h01, 6'h00};
    txt_rgb0 = 6'h2A; txt_rgb1 = 6'h3F;
    obj_rgb = 6'h0C; bg_rgb = 6'h01;
    text_valid = 1'b1; text_color = 1'b1; obj_valid = 1'b1; layer_en = 3'b111;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) text_valid = 1'b0;
      if (i == 2) obj_valid = 1'b0;
      if (i == 3) layer_en = 3'b000;
      tick(); tick();
      checks++;
      if (rgb_out !== exp_rgb[i]) begin
        errors++; $display("FAIL priority_%0d got %h want %h", i, rgb_out, exp_rgb[i]);
      end
    end
    layer_en = 3'b111; text_valid = 1'b1; text_color = 1'b0;
    tick(); tick();
    checks++; if (rgb_out !== 6'h2A) begin errors++; $display("FAIL palette0 got %h want 2A", rgb_out); end
    text_valid = 1'b0;
  endtask

  task automatic test_blank_align();
    layer_en = 3'b001; visible_in = 1'b0; bg_rgb = 6'h15;
    tick(); tick();
    checks++; if (rgb_out !== 6'h00) begin errors++; $display("FAIL blank_rgb got %h want 00", rgb_out); end
    checks++; if (visible_out !== 1'b0) begin errors++; $display("FAIL blank_visible got %b want 0", visible_out); end
    visible_in = 1'b1; hsync_in = 1'b0;
    tick();
    hsync_in = 1'b1; bg_rgb = 6'h07;
    checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL hsync_early got %b want 1", hsync_out); end
    tick();
    checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL hsync_aligned got %b want 0", hsync_out); end
    checks++; if (rgb_out !== 6'h15) begin errors++; $display("FAIL hsync_pixel got %h want 15", rgb_out); end
    tick();
    checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL hsync_end got %b want 1", hsync_out); end
    checks++; if (rgb_out !== 6'h07) begin errors++; $display("FAIL hsync_next_pixel got %h want 07", rgb_out); end
  endtask

  // Phase observed during the frame leading up to each of six frame events.
  task automatic test_blink();
    logic exp_ph [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    blink_en = 1'b1; layer_en = 3'b111;
    text_valid = 1'b1; text_color = 1'b1; obj_valid = 1'b1; obj_rgb = 6'h0C;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (blink_phase !== exp_ph[i]) begin
        errors++; $display("FAIL blink_frame_%0d got %b want %b", i, blink_phase, exp_ph[i]);
      end
      tick(); tick();
      checks++;
      if (rgb_out !== (exp_ph[i] ? 6'h3F : 6'h0C)) begin
        errors++; $display("FAIL blink_pixel_%0d got %h want %h", i, rgb_out, exp_ph[i] ? 6'h3F : 6'h0C);
      end
      vsync_pulse();
    end
    checks++; if (blink_phase !== 1'b0) begin errors++; $display("FAIL blink_after6 got %b want 0", blink_phase); end
  endtask

  task automatic test_blink_disable();
    blink_en = 1'b0;
    tick();
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL disable_show got %b want 1", blink_phase); end
    vsync_pulse();
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL disable_hold got %b want 1", blink_phase); end
    blink_en = 1'b1;
    vsync_pulse();
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL reenable_1 got %b want 1", blink_phase); end
    vsync_pulse();
    checks++; if (blink_phase !== 1'b0) begin errors++; $display("FAIL reenable_2 got %b want 0", blink_phase); end
  endtask

  task automatic test_async_reset();
    text_valid = 1'b0; obj_valid = 1'b0; layer_en = 3'b001;
    bg_rgb = 6'h22; hsync_in = 1'b0;
    tick(); tick();
    checks++; if (rgb_out !== 6'h22) begin errors++; $display("FAIL pre_reset_rgb got %h want 22", rgb_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rgb_out !== 6'h00) begin errors++; $display("FAIL async_rgb got %h want 00", rgb_out); end
    checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL async_hsync got %b want 1", hsync_out); end
    checks++; if (visible_out !== 1'b0) begin errors++; $display("FAIL async_visible got %b want 0", visible_out); end
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL async_blink got %b want 1", blink_phase); end
    tick();
    rst = 1'b0; hsync_in = 1'b1; bg_rgb = 6'h0B;
    tick();
    checks++; if (rgb_out !== 6'h00) begin errors++; $display("FAIL post_reset_early got %h want 00", rgb_out); end
    tick();
    checks++; if (rgb_out !== 6'h0B) begin errors++; $display("FAIL post_reset_pixel got %h want 0B", rgb_out); end
    checks++; if (visible_out !== 1'b1) begin errors++; $display("FAIL post_reset_visible got %b want 1", visible_out); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_blank_align();
    test_blink();
    test_blink_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
